// File: rtl/sort_host_if.sv
// Bundled stream and sorter-bus signals for sort_host: producer side (in_*),
// consumer side (out_*) and the sorter load/start/readback bus (s_*).
interface sort_host_if #(
  parameter int DW = 8,
  parameter int AW = 3
) ();
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          s_start;
  logic          s_wr;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_datain;
  logic [DW-1:0] s_dataout;
  logic          s_ready;

  // Host view: drives the ready/valid answers and the sorter bus.
  modport master (
    input  in_valid, in_data, out_ready, s_dataout, s_ready,
    output in_ready, out_valid, out_data, out_last,
           s_start, s_wr, s_addr, s_datain
  );

  // Environment view: producer, consumer and sorter together.
  modport slave (
    output in_valid, in_data, out_ready, s_dataout, s_ready,
    input  in_ready, out_valid, out_data, out_last,
           s_start, s_wr, s_addr, s_datain
  );
endinterface

// File: rtl/sort_host.sv
// Host for the 8-entry byte sorter: loads a batch, kicks the sort, reads back and streams out.
// Define SORT_HOST_DESC_EN to emit the batch largest first (readback address 7-cnt).
module sort_host #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic        clk,
  input  logic        rst,
  sort_host_if.master bus,
  output logic        busy,
  output logic [2:0]  dbg_state
);
  // Handshakes: a byte moves on in_* / out_* only in a cycle where valid and
  // ready are both high at the rising edge; out_* stays frozen while out_ready is low.
  typedef enum logic [2:0] {
    LOAD, KICK, WAIT_LO, WAIT_HI, RD_ADDR, RD_CAP, SEND
  } state_t;

  localparam logic [AW-1:0] CNT_LAST = AW'((1 << AW) - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [AW-1:0] rd_idx;

`ifdef SORT_HOST_DESC_EN
  assign rd_idx = CNT_LAST - cnt_q;
`else
  assign rd_idx = cnt_q;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    case (state_q)
      LOAD: begin
        if (bus.in_valid) begin
          busy_d = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = KICK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      KICK:    state_d = WAIT_LO;
      // The sorter may still show ready in the cycle it samples start.
      WAIT_LO: if (!bus.s_ready) state_d = WAIT_HI;
      WAIT_HI: begin
        if (bus.s_ready) begin
          state_d = RD_ADDR;
          cnt_d   = '0;
        end
      end
      RD_ADDR: state_d = RD_CAP;
      RD_CAP: begin
        out_data_d  = bus.s_dataout;
        out_valid_d = 1'b1;
        out_last_d  = (cnt_q == CNT_LAST);
        state_d     = SEND;
      end
      SEND: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            busy_d  = 1'b0;
            state_d = LOAD;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = RD_ADDR;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  // Sorter bus is a pure decode of state; writes pass straight through in LOAD.
  always_comb begin
    bus.s_addr = '0;
    case (state_q)
      LOAD:            bus.s_addr = cnt_q;
      RD_ADDR, RD_CAP: bus.s_addr = rd_idx;
      default:         bus.s_addr = '0;
    endcase
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.s_wr      = (state_q == LOAD) && bus.in_valid;
  assign bus.s_datain  = bus.s_wr ? bus.in_data : '0;
  assign bus.s_start   = (state_q == KICK);
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;
  assign busy          = busy_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_sort_host.sv
// Directed bench for sort_host with a behavioural 8-entry sorter on the s_* bus.
module tb_sort_host;
  localparam int DW = 8;
  localparam int AW = 3;
`ifdef SORT_HOST_DESC_EN
  localparam bit DESC = 1'b1;
`else
  localparam bit DESC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [2:0] dbg_state;

  sort_host_if #(.DW(DW), .AW(AW)) bus ();

  sort_host #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- sorter model ----------------
  logic [DW-1:0] mem [8];
  logic [DW-1:0] rd_q = '0;
  logic          s_ready_q = 1'b1;
  int            sort_dly = 0;
  assign bus.s_dataout = rd_q;
  assign bus.s_ready   = s_ready_q;

  always @(posedge clk) begin
    logic [DW-1:0] tmp [8];
    logic [DW-1:0] t;
    if (bus.s_wr) mem[bus.s_addr] <= bus.s_datain;
    else          rd_q <= mem[bus.s_addr];
    if (bus.s_start) begin
      s_ready_q <= 1'b0;
      sort_dly  <= 4;
    end else if (sort_dly > 0) begin
      sort_dly <= sort_dly - 1;
      if (sort_dly == 1) begin
        for (int i = 0; i < 8; i++) tmp[i] = mem[i];
        for (int i = 0; i < 7; i++)
          for (int j = 0; j < 7 - i; j++)
            if (tmp[j] > tmp[j+1]) begin
              t = tmp[j]; tmp[j] = tmp[j+1]; tmp[j+1] = t;
            end
        for (int i = 0; i < 8; i++) mem[i] <= tmp[i];
        s_ready_q <= 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [DW-1:0] got_q [$];
  bit            got_last_q [$];
  logic [AW-1:0] wr_addr_q [$];
  logic [DW-1:0] exp_q [$];
  int            starts_n = 0;
  int            wr_err = 0;
  int            stab_err = 0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.out_data);
        got_last_q.push_back(bus.out_last);
      end
      if (bus.s_wr) wr_addr_q.push_back(bus.s_addr);
      if (bus.s_start) starts_n <= starts_n + 1;
      if (bus.s_wr !== (bus.in_valid && bus.in_ready)) wr_err <= wr_err + 1;
      if (bus.s_wr && bus.s_start) wr_err <= wr_err + 1;
      if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data || bus.out_last !== prev_last))
        stab_err <= stab_err + 1;
      if (prev_stall && (bus.s_wr || bus.s_start)) stab_err <= stab_err + 1;
      prev_stall <= bus.out_valid && !bus.out_ready;
      prev_data  <= bus.out_data;
      prev_last  <= bus.out_last;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  int total = 0;
  int bad   = 0;

  // ---------------- drivers ----------------
  task automatic clear_obs();
    got_q.delete(); got_last_q.delete(); wr_addr_q.delete(); exp_q.delete();
    starts_n = 0; wr_err = 0; stab_err = 0;
  endtask

  task automatic set_exp(input logic [DW-1:0] s [8]);
    for (int i = 0; i < 8; i++) exp_q.push_back(DESC ? s[7-i] : s[i]);
  endtask

  task automatic load_bytes(input logic [DW-1:0] v [8], input int n, input bit bubbles);
    for (int i = 0; i < n; i++) begin
      if (bubbles) begin
        bus.in_valid = 1'b0; bus.in_data = 8'hAA;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1; bus.in_data = v[i];
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.in_data = '0;
  endtask

  task automatic drain(input bit toggle, output bit timed_out);
    int cyc = 0;
    timed_out = 1'b0;
    while (got_q.size() < 8) begin
      if (cyc >= 600) begin timed_out = 1'b1; break; end
      bus.out_ready = toggle ? (cyc % 4 == 0) : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    bus.out_ready = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    total++; if ({bus.out_valid, bus.out_last, busy, bus.s_start, bus.s_wr} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=00000", {bus.out_valid, bus.out_last, busy, bus.s_start, bus.s_wr}); end
    total++; if (bus.out_data !== 8'd0 || bus.s_addr !== 3'd0 || bus.s_datain !== 8'd0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h exp=0", bus.out_data, bus.s_addr, bus.s_datain); end
    total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_sort(input string name, input logic [DW-1:0] v [8],
                           input logic [DW-1:0] s [8], input bit toggle, input bit bubbles);
    bit to;
    clear_obs();
    set_exp(s);
    load_bytes(v, 8, bubbles);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy_after_load got=%b exp=1", name, busy); end
    drain(toggle, to);
    total++; if (to) begin bad++; $display("FAIL %s_timeout got=%0d bytes exp=8", name, got_q.size()); end
    total++; if (got_q.size() != 8) begin bad++; $display("FAIL %s_count got=%0d exp=8", name, got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL %s_data[%0d] got=%0d exp=%0d", name, i, got_q[i], exp_q[i]); end
      total++; if (got_last_q[i] !== (i == 7)) begin bad++; $display("FAIL %s_last[%0d] got=%b exp=%b", name, i, got_last_q[i], (i == 7)); end
    end
    total++; if (starts_n != 1) begin bad++; $display("FAIL %s_starts got=%0d exp=1", name, starts_n); end
    total++; if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL %s_idle got busy=%b in_ready=%b exp busy=0 in_ready=1", name, busy, bus.in_ready); end
    total++; if (wr_err != 0) begin bad++; $display("FAIL %s_wr_rules got=%0d exp=0", name, wr_err); end
    total++; if (stab_err != 0) begin bad++; $display("FAIL %s_stall_stable got=%0d exp=0", name, stab_err); end
    total++; if (wr_addr_q.size() != 8) begin bad++; $display("FAIL %s_wr_count got=%0d exp=8", name, wr_addr_q.size()); end
    for (int i = 0; i < 8 && i < wr_addr_q.size(); i++) begin
      total++; if (wr_addr_q[i] !== 3'(i)) begin bad++; $display("FAIL %s_wr_addr[%0d] got=%0d exp=%0d", name, i, wr_addr_q[i], i); end
    end
  endtask

  task automatic test_mid_reset();
    clear_obs();
    load_bytes('{8'd200, 8'd201, 8'd202, 8'd203, 8'd0, 8'd0, 8'd0, 8'd0}, 4, 1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
    rst = 1'b1; #2;
    total++; if (busy !== 1'b0 || bus.in_ready !== 1'b1 || dbg_state !== 3'd0) begin
      bad++; $display("FAIL midrst_async got busy=%b in_ready=%b state=%0d exp 0/1/0", busy, bus.in_ready, dbg_state); end
    @(posedge clk); #1; rst = 1'b0;
    test_sort("midrst", '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
              '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_sort("basic", '{8'd5, 8'd3, 8'd8, 8'd1, 8'd7, 8'd2, 8'd6, 8'd4},
              '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 1'b0, 1'b0);
    test_sort("dups", '{8'd9, 8'd9, 8'd0, 8'd255, 8'd9, 8'd0, 8'd128, 8'd1},
              '{8'd0, 8'd0, 8'd1, 8'd9, 8'd9, 8'd9, 8'd128, 8'd255}, 1'b0, 1'b0);
    test_sort("backpressure", '{8'd5, 8'd3, 8'd8, 8'd1, 8'd7, 8'd2, 8'd6, 8'd4},
              '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 1'b1, 1'b0);
    test_sort("bubbles", '{8'd40, 8'd10, 8'd70, 8'd20, 8'd80, 8'd30, 8'd60, 8'd50},
              '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80}, 1'b0, 1'b1);
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
